// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal (BCD) arithmetic datapath.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
    return nibble <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor: d = a_d - b_d - bin, wrapped into 0..9 with borrow out.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic signed [4:0] t;
  logic signed [4:0] t_adj;

  // Range is -16..15 even for non-BCD nibbles, so 5 signed bits never overflow.
  always_comb begin
    t     = $signed({1'b0, a_d}) - $signed({1'b0, b_d}) - $signed({4'b0000, bin});
    t_adj = t + 5'sd10;
    if (t < 0) begin
      d    = t_adj[DIGIT_W-1:0];
      bout = 1'b1;
    end else begin
      d    = t[DIGIT_W-1:0];
      bout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor: one digit per clock, LSD first, start/done handshake.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] diff,
  output logic                      borrow,
  output logic                      invalid
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t state, state_nxt;

  logic [W-1:0]       a_r, b_r;
  logic               inv_r;
  logic [IDX_W-1:0]   idx;
  logic               bin_r;
  logic               accept;
  logic               last;
  logic [DIGIT_W-1:0] a_d, b_d, d;
  logic               bout;

  function automatic logic all_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & is_bcd(v[i*DIGIT_W +: DIGIT_W]);
    end
    return ok;
  endfunction

  assign a_d  = a_r[idx*DIGIT_W +: DIGIT_W];
  assign b_d  = b_r[idx*DIGIT_W +: DIGIT_W];
  assign last = (idx == LAST_IDX);

  bcd_digit_sub u_digit (
    .a_d  (a_d),
    .b_d  (b_d),
    .bin  (bin_r),
    .d    (d),
    .bout (bout)
  );

  always_comb begin
    accept    = start && (state == IDLE || state == DONE);
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operands are captured only on an accepted start; CALC never re-latches them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r   <= a;
      b_r   <= b;
      inv_r <= !(all_bcd(a) && all_bcd(b));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
      bin_r   <= 1'b0;
    end else if (accept) begin
      busy    <= 1'b1;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
      bin_r   <= 1'b0;
    end else if (state == CALC) begin
      // Invalid operands leave diff at its cleared value so it reads 0 at done.
      if (!inv_r) diff[idx*DIGIT_W +: DIGIT_W] <= d;
      bin_r <= bout;
      idx   <= idx + 1'b1;
      if (last) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        borrow  <= inv_r ? 1'b0 : bout;
        invalid <= inv_r;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Scoreboard bench for bcd_serial_sub (DIGITS=4) with directed, hand-computed vectors.
module tb_bcd_serial_sub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         inv;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, invalid;
  logic [W-1:0] diff;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .borrow  (borrow),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff",       32'(diff),    32'(e.diff));
        check("borrow",     32'(borrow),  32'(e.borrow));
        check("invalid",    32'(invalid), 32'(e.inv));
        check("done_cycle", 32'(cyc),     32'(e.cyc));
        check("busy_at_done", 32'(busy),  32'd0);
      end
    end
  end

  function automatic exp_t mk(input logic [W-1:0] d, input logic br, input logic inv, input int c);
    exp_t e;
    e.diff = d; e.borrow = br; e.inv = inv; e.cyc = c;
    return e;
  endfunction

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input logic ei);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(mk(ed, eb, ei, cyc + 1 + DIGITS));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_after_start", 32'(done), 32'd0);
    drain();
    repeat (2) @(negedge clk);
    check("diff_hold", 32'(diff), 32'(ed));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_diff",    32'(diff),    32'd0);
    check("rst_borrow",  32'(borrow),  32'd0);
    check("rst_invalid", 32'(invalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0);
    do_op(16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);
    do_op(16'h5000, 16'h5000, 16'h0000, 1'b0, 1'b0);
    do_op(16'h0001, 16'h9999, 16'h0002, 1'b1, 1'b0);
    do_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1);
    do_op(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0);

    // start held high; operands change during CALC; second op accepted in DONE
    @(negedge clk);
    a = 16'h1234; b = 16'h0567; start = 1'b1;
    exp_q.push_back(mk(16'h0667, 1'b0, 1'b0, cyc + 1 + DIGITS));
    @(negedge clk);
    a = 16'h0000; b = 16'h0001;
    repeat (DIGITS) @(negedge clk);
    check("done_in_held", 32'(done), 32'd1);
    exp_q.push_back(mk(16'h9999, 1'b1, 1'b0, cyc + 1 + DIGITS));
    @(negedge clk);
    start = 1'b0;
    check("busy_b2b", 32'(busy), 32'd1);
    drain();

    // reset after two CALC edges aborts the operation
    @(negedge clk);
    a = 16'h1234; b = 16'h0567; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_done",    32'(done),    32'd0);
    check("abort_diff",    32'(diff),    32'd0);
    check("abort_borrow",  32'(borrow),  32'd0);
    check("abort_invalid", 32'(invalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_op(16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
